// File: rtl/if_fetch_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage: bus widths,
// control constants, FSM encodings and the byte-insertion helper.
package if_fetch_pkg;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;
    localparam logic Jump       = 1'b1;
    localparam logic NotJump    = 1'b0;
    localparam logic Stop       = 1'b1;
    localparam logic NoStop     = 1'b0;

    localparam int InstAddrBusW = 32;
    localparam int InstBusW     = 32;
    localparam int ByteCntW     = 2;

    typedef logic [InstAddrBusW-1:0] inst_addr_t;
    typedef logic [InstBusW-1:0]     inst_t;
    typedef logic [ByteCntW-1:0]     byte_cnt_t;

    localparam inst_t     ZeroWord  = 32'h0000_0000;
    localparam byte_cnt_t ByteFirst = 2'd0;
    localparam byte_cnt_t ByteLast  = 2'd3;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

    // Little-endian placement of one returned byte into the word under assembly.
    function automatic inst_t insert_byte(input inst_t word, input byte_cnt_t idx,
                                          input logic [7:0] data);
        inst_t w;
        w = word;
        w[8*idx +: 8] = data;
        return w;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide instruction memory port: the fetch stage is master, memory is slave.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic       mem_req;
    inst_addr_t mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/if_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup,
// synchronous write, valid bits cleared by reset only.
module if_fetch_icache
    import if_fetch_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] rd_addr,
    output logic        rd_hit,
    output inst_t       rd_data,
    input  logic        wr_en,
    input  logic [29:0] wr_addr,
    input  inst_t       wr_data
);

    localparam int IdxW = $clog2(LINES);
    localparam int TagW = 30 - IdxW;

    logic [LINES-1:0] valid_r;
    logic [TagW-1:0]  tag_r [LINES];
    inst_t            data_r [LINES];

    logic [IdxW-1:0] rd_idx_s;
    logic [IdxW-1:0] wr_idx_s;
    logic [TagW-1:0] rd_tag_s;
    logic [TagW-1:0] wr_tag_s;

    assign rd_idx_s = rd_addr[IdxW-1:0];
    assign rd_tag_s = rd_addr[29:IdxW];
    assign wr_idx_s = wr_addr[IdxW-1:0];
    assign wr_tag_s = wr_addr[29:IdxW];

    // Line valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            valid_r <= {LINES{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx_s] <= 1'b1;
        end
    end

    // Tag and data storage; only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx_s]  <= wr_tag_s;
            data_r[wr_idx_s] <= wr_data;
        end
    end

    // Lookup.
    always_comb begin
        rd_hit  = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
        rd_data = data_r[rd_idx_s];
    end

endmodule

// File: rtl/if_fetch.sv
// RV32I instruction-fetch stage: assembles each instruction from four byte
// handshakes and presents it to IF/ID. Optional instruction cache: ICACHE_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000
`ifdef ICACHE_EN
    ,
    parameter int ICACHE_LINES = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_if,
    input  logic       jump,
    input  inst_addr_t jump_addr,
    if_fetch_if.master mem,
    output inst_addr_t if_pc,
    output inst_t      if_inst,
    output logic       if_valid,
    output logic       stallreq_if
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    inst_addr_t   pc_r;
    byte_cnt_t    byte_cnt_r;
    inst_t        word_r;

    inst_t      fill_word_s;
    inst_addr_t redirect_s;
    logic       ack_s;
    logic       last_byte_s;
    logic       cache_hit_s;
    inst_t      cache_data_s;

`ifdef ICACHE_EN
    logic cache_raw_hit_s;
    logic cache_we_s;

    // A line is only filled by a fetch that ran to completion.
    assign cache_we_s  = last_byte_s && (jump == NotJump);
    assign cache_hit_s = cache_raw_hit_s && (state_r == S_REQ) && (byte_cnt_r == ByteFirst);

    if_fetch_icache #(
        .LINES   (ICACHE_LINES)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (pc_r[31:2]),
        .rd_hit  (cache_raw_hit_s),
        .rd_data (cache_data_s),
        .wr_en   (cache_we_s),
        .wr_addr (pc_r[31:2]),
        .wr_data (fill_word_s)
    );
`else
    assign cache_hit_s  = 1'b0;
    assign cache_data_s = ZeroWord;
`endif

    // Acks are only meaningful while a byte request is actually on the bus.
    assign ack_s       = (state_r == S_REQ) && !cache_hit_s && mem.mem_ack;
    assign last_byte_s = ack_s && (byte_cnt_r == ByteLast);
    assign fill_word_s = insert_byte(word_r, byte_cnt_r, mem.mem_rdata);
    assign redirect_s  = jump_addr & 32'hFFFF_FFFC;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_r <= S_REQ;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a jump overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (jump == Jump) begin
            state_nxt_s = S_REQ;
        end else begin
            case (state_r)
                S_REQ: begin
                    if (cache_hit_s || last_byte_s) begin
                        state_nxt_s = S_HOLD;
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end
                S_HOLD: begin
                    if (stall_if == Stop) begin
                        state_nxt_s = S_HOLD;
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end
                default: state_nxt_s = S_REQ;
            endcase
        end
    end

    // FSM outputs: memory request and stall request, both forced low in reset.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_addr = pc_r + {30'b0, byte_cnt_r};
        stallreq_if  = 1'b0;
        if (rst == RstEnable) begin
            mem.mem_req = 1'b0;
            stallreq_if = 1'b0;
        end else begin
            mem.mem_req = (state_r == S_REQ) && !cache_hit_s;
            stallreq_if = (state_r == S_REQ);
        end
    end

    // PC, byte counter and partial word; a dropped same-cycle ack is simply not stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            pc_r       <= RESET_PC;
            byte_cnt_r <= ByteFirst;
            word_r     <= ZeroWord;
        end else if (jump == Jump) begin
            pc_r       <= redirect_s;
            byte_cnt_r <= ByteFirst;
        end else if (state_r == S_REQ) begin
            if (ack_s) begin
                word_r     <= fill_word_s;
                byte_cnt_r <= byte_cnt_r + 2'd1;
            end
        end else if (stall_if == NoStop) begin
            pc_r       <= pc_r + 32'd4;
            byte_cnt_r <= ByteFirst;
        end
    end

    // IF/ID-facing registers; pc/inst only change when an instruction completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            if_pc    <= ZeroWord;
            if_inst  <= ZeroWord;
            if_valid <= 1'b0;
        end else if (jump == Jump) begin
            if_valid <= 1'b0;
        end else if (state_r == S_REQ) begin
            if (cache_hit_s) begin
                if_pc    <= pc_r;
                if_inst  <= cache_data_s;
                if_valid <= 1'b1;
            end else if (last_byte_s) begin
                if_pc    <= pc_r;
                if_inst  <= fill_word_s;
                if_valid <= 1'b1;
            end
        end else if (stall_if == NoStop) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte-wide memory responder with programmable
// wait states, address-contract monitor and immediate-assertion checks.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        jump;
    logic [31:0] jump_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        stallreq_if;

    int n_cmp    = 0;
    int n_err    = 0;
    int wait_cfg = 0;
    int wcnt     = 0;
    int hs_cnt   = 0;
    int viol     = 0;
    int hs0      = 0;
    logic        hold_v    = 1'b0;
    logic [31:0] hold_addr = 32'h0;

    if_fetch_if mem_bus ();

    if_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall_if    (stall_if),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .mem         (mem_bus),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_valid    (if_valid),
        .stallreq_if (stallreq_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_byte = 8'h13;
            32'h0000_0001: mem_byte = 8'h05;
            32'h0000_0002: mem_byte = 8'h10;
            32'h0000_0003: mem_byte = 8'h00;
            default:       mem_byte = a[7:0] + 8'h30;
        endcase
    endfunction

    assign mem_bus.mem_rdata = mem_byte(mem_bus.mem_addr);
    assign mem_bus.mem_ack   = mem_bus.mem_req && (wcnt >= wait_cfg);

    // Memory wait-state counter, handshake counter and address-stability monitor.
    always @(posedge clk) begin
        if (mem_bus.mem_req && mem_bus.mem_ack) hs_cnt <= hs_cnt + 1;
        if (hold_v && (!mem_bus.mem_req || mem_bus.mem_addr !== hold_addr)) viol <= viol + 1;
        hold_v    <= mem_bus.mem_req && !mem_bus.mem_ack && !jump && !rst;
        hold_addr <= mem_bus.mem_addr;
        if (!mem_bus.mem_req || mem_bus.mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall_if = 1'b1; jump = 1'b0; jump_addr = 32'h0;
        #1;
        chk("rst_req", mem_bus.mem_req, 32'd0);
        chk("rst_stallreq", stallreq_if, 32'd0);
        chk("rst_valid", if_valid, 32'd0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        rst = 1'b0;

        // Two bytes in, then reset mid-fetch.
        tick(); tick();
        chk("pre_rst_addr", mem_bus.mem_addr, 32'h2);
        rst = 1'b1; #1;
        chk("midrst_req", mem_bus.mem_req, 32'd0);
        rst = 1'b0; #1;
        chk("restart_addr", mem_bus.mem_addr, 32'h0);
        chk("restart_req", mem_bus.mem_req, 32'd1);
        chk("restart_stallreq", stallreq_if, 32'd1);
        chk("restart_valid", if_valid, 32'd0);

        // Zero-wait fetch at 0x0.
        tick();
        chk("zw_addr1", mem_bus.mem_addr, 32'h1);
        chk("zw_valid_early", if_valid, 32'd0);
        tick(); tick();
        chk("zw_addr3", mem_bus.mem_addr, 32'h3);
        tick();
        chk("zw_valid", if_valid, 32'd1);
        chk("zw_inst", if_inst, 32'h0010_0513);
        chk("zw_pc", if_pc, 32'h0);
        chk("hold_req", mem_bus.mem_req, 32'd0);
        chk("hold_stallreq", stallreq_if, 32'd0);

        // Stall in S_HOLD for four cycles.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_inst", if_inst, 32'h0010_0513);
            chk("stall_pc", if_pc, 32'h0);
            chk("stall_req", mem_bus.mem_req, 32'd0);
            chk("stall_valid", if_valid, 32'd1);
        end
        stall_if = 1'b0;
        tick();
        chk("consume_addr", mem_bus.mem_addr, 32'h4);
        chk("consume_req", mem_bus.mem_req, 32'd1);
        chk("consume_valid", if_valid, 32'd0);
        chk("consume_inst", if_inst, 32'h0010_0513);

        // Three wait states per byte at 0x4: address held until each ack.
        wait_cfg = 3; stall_if = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("ws_addr", mem_bus.mem_addr, 32'h4 + 32'(i / 4));
        end
        tick();
        chk("ws_valid", if_valid, 32'd1);
        chk("ws_inst", if_inst, 32'h3736_3534);
        chk("ws_pc", if_pc, 32'h4);

        // Jump after byte 2 of the fetch at 0x8, with an ack in the same cycle.
        wait_cfg = 0; stall_if = 1'b0;
        tick();
        chk("j_addr0", mem_bus.mem_addr, 32'h8);
        tick(); tick();
        chk("j_addr2", mem_bus.mem_addr, 32'hA);
        jump = 1'b1; jump_addr = 32'h102; #1;
        chk("j_ack_same", mem_bus.mem_ack, 32'd1);
        tick();
        jump = 1'b0; stall_if = 1'b1;
        chk("j_addr", mem_bus.mem_addr, 32'h100);
        chk("j_valid", if_valid, 32'd0);
        chk("j_req", mem_bus.mem_req, 32'd1);
        chk("j_inst_keep", if_inst, 32'h3736_3534);
        chk("j_pc_keep", if_pc, 32'h4);
        tick();
        chk("j_addr_b1", mem_bus.mem_addr, 32'h101);
        tick(); tick(); tick();
        chk("j_fill_valid", if_valid, 32'd1);
        chk("j_fill_inst", if_inst, 32'h3332_3130);
        chk("j_fill_pc", if_pc, 32'h100);

        // Jump while stalled in S_HOLD still redirects; low target bits are dropped.
        jump = 1'b1; jump_addr = 32'hFFFF_FFFF;
        tick();
        jump = 1'b0;
        chk("jh_addr", mem_bus.mem_addr, 32'hFFFF_FFFC);
        chk("jh_valid", if_valid, 32'd0);
        chk("jh_pc_keep", if_pc, 32'h100);
        repeat (4) tick();
        chk("wrap_inst", if_inst, 32'h2F2E_2D2C);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        stall_if = 1'b0;
        tick();
        chk("wrap_addr", mem_bus.mem_addr, 32'h0);

        // Loop to 0x40: first pass always goes to memory.
        jump = 1'b1; jump_addr = 32'h40; stall_if = 1'b1;
        tick();
        jump = 1'b0;
        hs0 = hs_cnt;
        repeat (4) tick();
        chk("c1_valid", if_valid, 32'd1);
        chk("c1_inst", if_inst, 32'h7372_7170);
        chk("c1_hs", 32'(hs_cnt - hs0), 32'd4);

        // Second pass to 0x40.
        jump = 1'b1; jump_addr = 32'h40;
        tick();
        jump = 1'b0;
        hs0 = hs_cnt;
`ifdef ICACHE_EN
        chk("c2_req", mem_bus.mem_req, 32'd0);
        tick();
        chk("c2_valid", if_valid, 32'd1);
        chk("c2_inst", if_inst, 32'h7372_7170);
        chk("c2_pc", if_pc, 32'h40);
        chk("c2_hs", 32'(hs_cnt - hs0), 32'd0);
`else
        chk("c2_req", mem_bus.mem_req, 32'd1);
        tick();
        chk("c2_valid_early", if_valid, 32'd0);
        repeat (3) tick();
        chk("c2_valid", if_valid, 32'd1);
        chk("c2_inst", if_inst, 32'h7372_7170);
        chk("c2_pc", if_pc, 32'h40);
        chk("c2_hs", 32'(hs_cnt - hs0), 32'd4);
`endif

        chk("addr_contract", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
